mem_burst_ctrl: RTL and testbench
=================================

Name: mem_burst_ctrl

Overview:
- Command-driven burst controller placed directly upstream of the single-port, 1024x8 synchronous-write, combinational-read memory.
- Sole driver of the memory's addr, we and data_input; sole consumer of its data_output.
- Converts burst commands (start address, length, direction) into a valid/ready write stream into memory, or a valid/ready read stream out of memory.

Parameters:
- DATA_WIDTH, 8, memory word width.
- ADDR_WIDTH, 10, memory address width.
- LEN_WIDTH, 8, burst length field width; a burst is 1..2^LEN_WIDTH-1 words.

Ports:
- clk  input  1  clock
- rst  input  1  reset, synchronous, active-high
- cmd_valid  input  1  command offered
- cmd_ready  output  1  controller accepts command (high only in IDLE)
- cmd_write  input  1  1 = write burst, 0 = read burst
- cmd_addr  input  ADDR_WIDTH  burst start address
- cmd_len  input  LEN_WIDTH  number of words
- wr_valid  input  1  write data offered
- wr_ready  output  1  write data accepted
- wr_data  input  DATA_WIDTH  write data
- rd_valid  output  1  read data valid
- rd_ready  input  1  read data consumed
- rd_data  output  DATA_WIDTH  read data (registered)
- mem_addr  output  ADDR_WIDTH  to memory addr
- mem_we  output  1  to memory we
- mem_wdata  output  DATA_WIDTH  to memory data_input
- mem_rdata  input  DATA_WIDTH  from memory data_output
- busy  output  1  high in any state other than IDLE
- done  output  1  one-cycle pulse at burst completion

Behaviour:
- Reset values: state IDLE; cmd_ready=1; wr_ready=0; rd_valid=0; rd_data=0; mem_addr=0; mem_we=0; mem_wdata=0; busy=0; done=0.
- Reset mid-burst aborts immediately to IDLE. Memory contents are left as already written. Partial read data is discarded.
- States:
  - IDLE
    - Handshake is cmd_valid && cmd_ready.
    - Latch cmd_addr into cur_addr and cmd_len into remaining.
    - Next state is WRITE if cmd_write=1, else READ.
    - cmd_len=0: go straight to DONE; no memory access, no data handshakes.
  - WRITE
    - wr_ready=1. mem_addr=cur_addr. mem_we=wr_valid. mem_wdata=wr_data (combinational pass-through).
    - On each wr_valid: the memory writes at the clock edge; cur_addr+1; remaining-1.
    - Accepting the last word (remaining=1): go to DONE.
  - READ
    - mem_we=0. mem_addr=cur_addr.
    - A fetch occurs when (!rd_valid || rd_ready) && remaining!=0. On a fetch: rd_data<=mem_rdata; rd_valid<=1; cur_addr+1; remaining-1.
    - Throughput is 1 word/cycle with rd_ready held high. First rd_valid appears one cycle after entering READ.
    - When rd_ready && rd_valid and no fetch occurs: rd_valid<=0.
    - When remaining=0 and the output register is empty or being consumed this cycle: go to DONE.
    - rd_data holds stable while rd_valid && !rd_ready.
  - DONE
    - done=1 for exactly one cycle; busy=1. Next state is IDLE.
- mem_we is 0 in every state except WRITE with wr_valid=1. mem_rdata is never sampled while mem_we=1, because memory output is high-impedance then.
- Address arithmetic is modulo 2^ADDR_WIDTH: address 1023 + 1 wraps to 0 within a burst.
- In IDLE and DONE, mem_addr holds its last value.
- cmd_valid during busy is ignored (cmd_ready=0); the command must be held until accepted.
- wr_valid outside WRITE has no effect (wr_ready=0, mem_we=0).
- rd_ready outside READ has no effect.
- Latency:
  - Write: word n lands in memory at the edge where it is accepted.
  - Read: word n is presented on rd_data one cycle after mem_addr=start+n.

Test Plan:
- Reset then write burst: addr=0x010, len=4, data A0,A1,A2,A3 with wr_valid held high -> mem_we high 4 consecutive cycles, mem_addr 0x010..0x013, done pulses the cycle after the 4th write, memory holds A0..A3.
- Read back the same range with rd_ready=1 -> rd_data A0,A1,A2,A3 on 4 consecutive cycles, rd_valid then drops, done pulses once, mem_we stays 0 throughout.
- Read len=3 with rd_ready toggling 1,0,0,1,1 -> each word presented exactly once, rd_data stable while stalled, no skipped or duplicated addresses.
- Wrap: write at addr=0x3FE, len=4, data 11,22,33,44 -> writes land at 0x3FE, 0x3FF, 0x000, 0x001; read-back matches.
- cmd_len=0 and cmd_valid while busy -> len=0 yields done in 2 cycles with no mem_we; a command held during a burst is accepted only on return to IDLE.
- Assert rst mid write burst after 2 of 5 words -> next cycle state IDLE, busy=0, mem_we=0, wr_ready=0; a subsequent burst runs normally.

Source files
------------

// File: rtl/mem_burst_ctrl.sv
// -----------------------------------------------------------------------------
// mem_burst_ctrl
//
// Burst controller that sits directly in front of a single-port memory with a
// synchronous write and a combinational read. It is the only driver of the
// memory's address, write enable and write data, and the only reader of the
// memory's read data. A command (start address, length, direction) is turned
// into either a write stream into memory or a read stream out of memory.
//
// Handshake semantics (cmd_*, wr_*, rd_*): a transfer happens on a rising clock
// edge where valid and ready are both high. The producer must hold valid and
// its payload stable until that edge. The consumer may raise or lower ready at
// any time. Ready never depends on valid in the same cycle.
//
// Ports:
//   clk, rst     clock; synchronous active-high reset
//   cmd_valid    command offered
//   cmd_ready    command accepted (high only in IDLE)
//   cmd_write    1 = write burst, 0 = read burst
//   cmd_addr     burst start address
//   cmd_len      number of words (0 = no access, just a done pulse)
//   wr_valid     write data offered
//   wr_ready     write data accepted (high only in WRITE)
//   wr_data      write data
//   rd_valid     read data valid
//   rd_ready     read data consumed
//   rd_data      read data (registered)
//   mem_addr     memory address
//   mem_we       memory write enable
//   mem_wdata    memory write data
//   mem_rdata    memory read data
//   busy         high whenever the controller is not in IDLE
//   done         one-cycle pulse when a burst completes
//   dbg_state    current FSM state (IDLE=0, WRITE=1, READ=2, DONE=3)
// -----------------------------------------------------------------------------
module mem_burst_ctrl #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 10,
  parameter int LEN_WIDTH  = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [LEN_WIDTH-1:0]  cmd_len,
  input  logic                  wr_valid,
  output logic                  wr_ready,
  input  logic [DATA_WIDTH-1:0] wr_data,
  output logic                  rd_valid,
  input  logic                  rd_ready,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic                  mem_we,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic                  busy,
  output logic                  done,
  output logic [1:0]            dbg_state
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    READ  = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = ADDR_WIDTH'(1);
  localparam logic [LEN_WIDTH-1:0]  LEN_ONE  = LEN_WIDTH'(1);
  localparam logic [LEN_WIDTH-1:0]  LEN_ZERO = '0;

  state_t                 state_q, state_d;
  logic [ADDR_WIDTH-1:0]  cur_addr_q, cur_addr_d;
  logic [LEN_WIDTH-1:0]   remaining_q, remaining_d;
  logic                   rd_valid_q, rd_valid_d;
  logic [DATA_WIDTH-1:0]  rd_data_q, rd_data_d;
  // Address shown on mem_addr while idle or done: the last address driven
  // during a burst, so the memory port does not toggle between bursts.
  logic [ADDR_WIDTH-1:0]  last_addr_q, last_addr_d;
  logic                   fetch;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cur_addr_q  <= '0;
      remaining_q <= '0;
      rd_valid_q  <= 1'b0;
      rd_data_q   <= '0;
      last_addr_q <= '0;
    end else begin
      state_q     <= state_d;
      cur_addr_q  <= cur_addr_d;
      remaining_q <= remaining_d;
      rd_valid_q  <= rd_valid_d;
      rd_data_q   <= rd_data_d;
      last_addr_q <= last_addr_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cur_addr_d  = cur_addr_q;
    remaining_d = remaining_q;
    rd_valid_d  = rd_valid_q;
    rd_data_d   = rd_data_q;
    last_addr_d = last_addr_q;
    fetch       = 1'b0;
    cmd_ready   = 1'b0;
    wr_ready    = 1'b0;
    mem_we      = 1'b0;
    mem_wdata   = '0;
    mem_addr    = last_addr_q;
    busy        = 1'b1;
    done        = 1'b0;

    unique case (state_q)
      IDLE: begin
        cmd_ready = 1'b1;
        busy      = 1'b0;
        if (cmd_valid) begin
          cur_addr_d  = cmd_addr;
          remaining_d = cmd_len;
          if (cmd_len == LEN_ZERO) begin
            state_d = DONE;
          end else if (cmd_write) begin
            state_d = WRITE;
          end else begin
            state_d = READ;
          end
        end
      end

      WRITE: begin
        // Write data passes straight through; the memory captures it at the
        // same edge where the word is accepted.
        wr_ready    = 1'b1;
        mem_addr    = cur_addr_q;
        last_addr_d = cur_addr_q;
        mem_we      = wr_valid;
        mem_wdata   = wr_data;
        if (wr_valid) begin
          cur_addr_d  = cur_addr_q + ADDR_ONE;
          remaining_d = remaining_q - LEN_ONE;
          if (remaining_q == LEN_ONE) begin
            state_d = DONE;
          end
        end
      end

      READ: begin
        mem_addr    = cur_addr_q;
        last_addr_d = cur_addr_q;
        // The output register can take a new word when it is empty or is
        // being drained this cycle; this keeps 1 word/cycle with rd_ready high.
        fetch = (!rd_valid_q || rd_ready) && (remaining_q != LEN_ZERO);
        if (fetch) begin
          rd_data_d   = mem_rdata;
          rd_valid_d  = 1'b1;
          cur_addr_d  = cur_addr_q + ADDR_ONE;
          remaining_d = remaining_q - LEN_ONE;
        end else if (rd_ready && rd_valid_q) begin
          rd_valid_d = 1'b0;
        end
        if ((remaining_q == LEN_ZERO) && (!rd_valid_q || rd_ready)) begin
          state_d = DONE;
        end
      end

      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign rd_valid  = rd_valid_q;
  assign rd_data   = rd_data_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_mem_burst_ctrl.sv
// -----------------------------------------------------------------------------
// tb_mem_burst_ctrl
//
// Directed bench for mem_burst_ctrl with a 1024x8 memory model (synchronous
// write, combinational read) attached to the memory port. Inputs are driven
// just after the falling edge and outputs are sampled 1 ns later, well away
// from the rising edge.
// -----------------------------------------------------------------------------
module tb_mem_burst_ctrl;

  logic       clk;
  logic       rst;
  logic       cmd_valid;
  logic       cmd_ready;
  logic       cmd_write;
  logic [9:0] cmd_addr;
  logic [7:0] cmd_len;
  logic       wr_valid;
  logic       wr_ready;
  logic [7:0] wr_data;
  logic       rd_valid;
  logic       rd_ready;
  logic [7:0] rd_data;
  logic [9:0] mem_addr;
  logic       mem_we;
  logic [7:0] mem_wdata;
  logic [7:0] mem_rdata;
  logic       busy;
  logic       done;
  logic [1:0] dbg_state;

  logic [7:0] mem [1024];
  logic       mem_init;
  logic [7:0] wdat [8];

  int n_run;
  int n_fail;

  mem_burst_ctrl #(
    .DATA_WIDTH(8),
    .ADDR_WIDTH(10),
    .LEN_WIDTH (8)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_write (cmd_write),
    .cmd_addr  (cmd_addr),
    .cmd_len   (cmd_len),
    .wr_valid  (wr_valid),
    .wr_ready  (wr_ready),
    .wr_data   (wr_data),
    .rd_valid  (rd_valid),
    .rd_ready  (rd_ready),
    .rd_data   (rd_data),
    .mem_addr  (mem_addr),
    .mem_we    (mem_we),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .busy      (busy),
    .done      (done),
    .dbg_state (dbg_state)
  );

  // clock / memory model
  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < 1024; i++) mem[i] <= 8'h00;
    end else if (mem_we) begin
      mem[mem_addr] <= mem_wdata;
    end
  end

  assign mem_rdata = mem[mem_addr];

  // checker
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_run++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // driver tasks: called at a falling edge, return at a falling edge
  task automatic send_cmd(input logic w, input logic [9:0] a, input logic [7:0] l);
    cmd_valid = 1'b1;
    cmd_write = w;
    cmd_addr  = a;
    cmd_len   = l;
    #1;
    chk("cmd_ready_idle", cmd_ready, 1);
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic write_burst(input logic [9:0] a, input int n);
    logic [9:0] ea;
    send_cmd(1'b1, a, n[7:0]);
    for (int i = 0; i < n; i++) begin
      ea       = a + i[9:0];
      wr_valid = 1'b1;
      wr_data  = wdat[i];
      #1;
      chk("wr_ready", wr_ready, 1);
      chk("wr_mem_we", mem_we, 1);
      chk("wr_mem_addr", mem_addr, ea);
      chk("wr_mem_wdata", mem_wdata, wdat[i]);
      @(negedge clk);
    end
    wr_valid = 1'b0;
    #1;
    chk("wr_done", done, 1);
    chk("wr_done_busy", busy, 1);
    chk("wr_done_we", mem_we, 0);
    @(negedge clk);
    chk("wr_after_done", done, 0);
    chk("wr_after_busy", busy, 0);
    for (int i = 0; i < n; i++) begin
      ea = a + i[9:0];
      chk("wr_mem_content", mem[ea], wdat[i]);
    end
  endtask

  task automatic read_burst(input logic [9:0] a, input int n);
    send_cmd(1'b0, a, n[7:0]);
    rd_ready = 1'b1;
    #1;
    chk("rd_first_valid", rd_valid, 0);
    chk("rd_first_addr", mem_addr, a);
    chk("rd_first_we", mem_we, 0);
    @(negedge clk);
    for (int i = 0; i < n; i++) begin
      #1;
      chk("rd_valid", rd_valid, 1);
      chk("rd_data", rd_data, wdat[i]);
      chk("rd_we", mem_we, 0);
      @(negedge clk);
    end
    #1;
    chk("rd_valid_drop", rd_valid, 0);
    chk("rd_done", done, 1);
    @(negedge clk);
    chk("rd_after_done", done, 0);
    rd_ready = 1'b0;
  endtask

  logic       stall_rdy  [5];
  logic [7:0] stall_data [5];
  logic [9:0] stall_addr [5];

  initial begin
    n_run     = 0;
    n_fail    = 0;
    rst       = 1'b1;
    mem_init  = 1'b1;
    cmd_valid = 1'b0;
    cmd_write = 1'b0;
    cmd_addr  = '0;
    cmd_len   = '0;
    wr_valid  = 1'b0;
    wr_data   = '0;
    rd_ready  = 1'b0;

    // reset state
    repeat (2) @(negedge clk);
    rst      = 1'b0;
    mem_init = 1'b0;
    #1;
    chk("rst_state", dbg_state, 0);
    chk("rst_cmd_ready", cmd_ready, 1);
    chk("rst_wr_ready", wr_ready, 0);
    chk("rst_rd_valid", rd_valid, 0);
    chk("rst_rd_data", rd_data, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_we", mem_we, 0);
    chk("rst_mem_wdata", mem_wdata, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    @(negedge clk);

    // write 4 words at 0x010, read them back
    wdat[0] = 8'hA0; wdat[1] = 8'hA1; wdat[2] = 8'hA2; wdat[3] = 8'hA3;
    write_burst(10'h010, 4);
    read_burst(10'h010, 4);

    // read 3 words with a stalling consumer
    stall_rdy[0] = 1'b1; stall_data[0] = 8'hA0; stall_addr[0] = 10'h011;
    stall_rdy[1] = 1'b0; stall_data[1] = 8'hA1; stall_addr[1] = 10'h012;
    stall_rdy[2] = 1'b0; stall_data[2] = 8'hA1; stall_addr[2] = 10'h012;
    stall_rdy[3] = 1'b1; stall_data[3] = 8'hA1; stall_addr[3] = 10'h012;
    stall_rdy[4] = 1'b1; stall_data[4] = 8'hA2; stall_addr[4] = 10'h013;
    send_cmd(1'b0, 10'h010, 8'd3);
    rd_ready = 1'b0;
    #1;
    chk("stall_first_valid", rd_valid, 0);
    @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      rd_ready = stall_rdy[i];
      #1;
      chk("stall_rd_valid", rd_valid, 1);
      chk("stall_rd_data", rd_data, stall_data[i]);
      chk("stall_mem_addr", mem_addr, stall_addr[i]);
      @(negedge clk);
    end
    #1;
    chk("stall_done", done, 1);
    chk("stall_valid_drop", rd_valid, 0);
    @(negedge clk);
    rd_ready = 1'b0;

    // address wrap at the top of memory
    wdat[0] = 8'h11; wdat[1] = 8'h22; wdat[2] = 8'h33; wdat[3] = 8'h44;
    write_burst(10'h3FE, 4);
    chk("wrap_mem0", mem[10'h000], 8'h33);
    read_burst(10'h3FE, 4);

    // zero-length command
    send_cmd(1'b1, 10'h055, 8'd0);
    #1;
    chk("len0_state", dbg_state, 3);
    chk("len0_done", done, 1);
    chk("len0_busy", busy, 1);
    chk("len0_we", mem_we, 0);
    @(negedge clk);
    chk("len0_idle_done", done, 0);
    chk("len0_idle_busy", busy, 0);

    // command held during a write burst is taken only back in IDLE
    send_cmd(1'b1, 10'h100, 8'd2);
    cmd_valid = 1'b1;
    cmd_write = 1'b0;
    cmd_addr  = 10'h010;
    cmd_len   = 8'd1;
    for (int i = 0; i < 2; i++) begin
      wr_valid = 1'b1;
      wr_data  = 8'h5A + 8'(i);
      #1;
      chk("held_cmd_ready", cmd_ready, 0);
      chk("held_we", mem_we, 1);
      @(negedge clk);
    end
    wr_valid = 1'b0;
    #1;
    chk("held_done", done, 1);
    chk("held_done_ready", cmd_ready, 0);
    @(negedge clk);
    #1;
    chk("held_idle_ready", cmd_ready, 1);
    chk("held_idle_busy", busy, 0);
    @(negedge clk);
    cmd_valid = 1'b0;
    wr_valid  = 1'b1;
    rd_ready  = 1'b1;
    #1;
    chk("held_read_state", dbg_state, 2);
    chk("held_read_addr", mem_addr, 10'h010);
    chk("wr_valid_in_read_we", mem_we, 0);
    chk("wr_valid_in_read_ready", wr_ready, 0);
    @(negedge clk);
    #1;
    chk("held_rd_valid", rd_valid, 1);
    chk("held_rd_data", rd_data, 8'hA0);
    @(negedge clk);
    chk("held_rd_done", done, 1);
    wr_valid = 1'b0;
    rd_ready = 1'b0;
    @(negedge clk);
    chk("held_mem100", mem[10'h100], 8'h5A);
    chk("held_mem101", mem[10'h101], 8'h5B);

    // reset in the middle of a 5-word write burst
    send_cmd(1'b1, 10'h200, 8'd5);
    for (int i = 0; i < 2; i++) begin
      wr_valid = 1'b1;
      wr_data  = 8'hC0 + 8'(i);
      @(negedge clk);
    end
    wr_valid = 1'b0;
    rst      = 1'b1;
    @(negedge clk);
    wr_valid = 1'b1;
    #1;
    chk("abort_state", dbg_state, 0);
    chk("abort_busy", busy, 0);
    chk("abort_we", mem_we, 0);
    chk("abort_wr_ready", wr_ready, 0);
    chk("abort_cmd_ready", cmd_ready, 1);
    @(negedge clk);
    rst      = 1'b0;
    wr_valid = 1'b0;
    chk("abort_mem200", mem[10'h200], 8'hC0);
    chk("abort_mem201", mem[10'h201], 8'hC1);
    chk("abort_mem202", mem[10'h202], 8'h00);
    wdat[0] = 8'hE0; wdat[1] = 8'hE1; wdat[2] = 8'hE2; wdat[3] = 8'hE3; wdat[4] = 8'hE4;
    write_burst(10'h200, 5);
    read_burst(10'h200, 5);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
